cpu_sequencer: RTL and testbench

Parametrised multi-cycle instruction sequencer and controller for the CPU core. It drives the register-file and ALU datapath, the instruction ROM and the data RAM.
- Generalises the previous fixed 16-bit / 6-bit-address controller in register count, ROM depth and RAM depth.
- Adds instruction-fetch and data-memory wait-state handshakes, conditional and absolute branches, and an illegal-opcode flag.
- Signals end-of-execution to the RAM readout/UART stage.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_decoder.sv | 39 +++
 rtl/cpu_sequencer.sv | 142 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-select and result-source encodings, FSM states and the
// instruction-width derivation for the CPU sequencer and its decoder.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_AND = 3'b010;
  localparam logic [2:0] FS_OR  = 3'b011;
  localparam logic [2:0] FS_XOR = 3'b100;
  localparam logic [2:0] FS_NOT = 3'b101;

  localparam logic [1:0] RS_ALU   = 2'b00;
  localparam logic [1:0] RS_MEM   = 2'b01;
  localparam logic [1:0] RS_PASSA = 2'b10;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LD, CLS_ST, CLS_BR, CLS_JMP, CLS_HALT, CLS_ILL
  } op_class_t;

  // Opcode nibble plus three register/immediate fields.
  function automatic int instr_w(input int reg_aw);
    return 4 + 3 * reg_aw;
  endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Opcode to ALU select, B-mux, result source and instruction class.
// Purely combinational, zero latency, no handshake.
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter int FS_W = 3
) (
  input  logic [3:0]      opcode,
  output logic [FS_W-1:0] fs,
  output logic            mb,
  output logic [1:0]      result_src,
  output op_class_t       op_class
);

  always_comb begin
    fs         = '0;
    mb         = 1'b0;
    result_src = RS_ALU;
    op_class   = CLS_NOP;
    case (opcode)
      OP_NOP:  op_class = CLS_NOP;
      OP_ADD:  begin fs = FS_W'(FS_ADD); op_class = CLS_ALU; end
      OP_SUB:  begin fs = FS_W'(FS_SUB); op_class = CLS_ALU; end
      OP_AND:  begin fs = FS_W'(FS_AND); op_class = CLS_ALU; end
      OP_OR:   begin fs = FS_W'(FS_OR);  op_class = CLS_ALU; end
      OP_XOR:  begin fs = FS_W'(FS_XOR); op_class = CLS_ALU; end
      OP_NOT:  begin fs = FS_W'(FS_NOT); op_class = CLS_ALU; end
      OP_MOV:  begin result_src = RS_PASSA; op_class = CLS_ALU; end
      OP_LD:   begin result_src = RS_MEM; op_class = CLS_LD; end
      OP_ST:   op_class = CLS_ST;
      OP_ADDI: begin fs = FS_W'(FS_ADD); mb = 1'b1; op_class = CLS_ALU; end
      OP_BZ:   op_class = CLS_BR;
      OP_JMP:  op_class = CLS_JMP;
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/HALT controller: 2 cycles per ALU/branch op, 3 per LD/ST,
// stretched by instr_valid (FETCH) and mem_ready (MEM) wait states.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter  int REG_AW  = 4,
  parameter  int ROM_AW  = 6,
  parameter  int RAM_AW  = 6,
  parameter  int FS_W    = 3,
  localparam int INSTR_W = instr_w(REG_AW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               mem_ready,
  input  logic               a_zero,
  output logic [ROM_AW-1:0]  pc,
  output logic               rom_en,
  output logic [REG_AW-1:0]  da,
  output logic [REG_AW-1:0]  aa,
  output logic [REG_AW-1:0]  ba,
  output logic [FS_W-1:0]    fs,
  output logic               mb,
  output logic [1:0]         result_src,
  output logic               rw,
  output logic               mw,
  output logic               mem_req,
  output logic               eoe,
  output logic               illegal
);

  localparam int OFF_W = 2 * REG_AW;
  localparam int EXT_W = ROM_AW + OFF_W;

  // JMP takes its target from the low IR bits, so the PC must fit below the opcode.
  if (ROM_AW > INSTR_W - 4 || RAM_AW < 1) begin : g_bad_params
    $error("cpu_sequencer: ROM_AW exceeds JMP field or RAM_AW invalid");
  end

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [ROM_AW-1:0]  pc_nxt, pc_inc, pc_br;
  logic               ir_load, set_illegal;
  logic [3:0]         opcode;
  logic [REG_AW-1:0]  ir_da, ir_aa, ir_ba;
  logic [OFF_W-1:0]   br_off;
  logic [FS_W-1:0]    dec_fs;
  logic               dec_mb;
  logic [1:0]         dec_rs;
  op_class_t          op_class;

  assign opcode = ir[INSTR_W-1 -: 4];
  assign ir_da  = ir[3*REG_AW-1:2*REG_AW];
  assign ir_aa  = ir[2*REG_AW-1:REG_AW];
  assign ir_ba  = ir[REG_AW-1:0];
  assign br_off = {ir_da, ir_ba};
  assign pc_inc = pc + ROM_AW'(1);
  assign pc_br  = ROM_AW'(EXT_W'(pc) + {{ROM_AW{br_off[OFF_W-1]}}, br_off});

  cpu_decoder #(.FS_W(FS_W)) u_decoder (
    .opcode     (opcode),
    .fs         (dec_fs),
    .mb         (dec_mb),
    .result_src (dec_rs),
    .op_class   (op_class)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_load)     ir      <= instr;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_load     = 1'b0;
    set_illegal = 1'b0;
    rom_en      = 1'b0;
    rw          = 1'b0;
    mw          = 1'b0;
    mem_req     = 1'b0;
    eoe         = 1'b0;
    da          = '0;
    aa          = '0;
    ba          = '0;
    fs          = '0;
    mb          = 1'b0;
    result_src  = RS_ALU;
    if (state == EXEC || state == MEM) begin
      da         = ir_da;
      aa         = ir_aa;
      ba         = ir_ba;
      fs         = dec_fs;
      mb         = dec_mb;
      result_src = dec_rs;
    end
    case (state)
      FETCH: begin
        // Gated by reset so the ROM is not enabled while reset is held.
        rom_en = reset;
        if (instr_valid) begin
          ir_load   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        case (op_class)
          CLS_NOP:  pc_nxt = pc_inc;
          CLS_ALU:  begin rw = 1'b1; pc_nxt = pc_inc; end
          CLS_ILL:  begin set_illegal = 1'b1; pc_nxt = pc_inc; end
          CLS_BR:   pc_nxt = a_zero ? pc_br : pc_inc;
          CLS_JMP:  pc_nxt = ir[ROM_AW-1:0];
          CLS_LD:   state_nxt = MEM;
          CLS_ST:   state_nxt = MEM;
          CLS_HALT: state_nxt = HALT;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        mw      = (op_class == CLS_ST);
        if (mem_ready) begin
          rw        = (op_class == CLS_LD);
          pc_nxt    = pc_inc;
          state_nxt = FETCH;
        end
      end
      HALT: eoe = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: expected fetch addresses and register/memory
// strobes are queued by the stimulus and consumed by an independent monitor.
module tb_cpu_sequencer;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [3:0] da;
    logic [3:0] aa;
    logic [3:0] ba;
    logic [2:0] fs;
    logic       mb;
    logic [1:0] rs;
  } strobe_t;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic        a_zero;
  logic [5:0]  pc;
  logic        rom_en;
  logic [3:0]  da, aa, ba;
  logic [2:0]  fs;
  logic        mb;
  logic [1:0]  result_src;
  logic        rw, mw, mem_req, eoe, illegal;

  int errors = 0;
  int checks = 0;
  int req_len = 0, mw_len = 0, last_req_len = 0, last_mw_len = 0;
  logic [5:0] fetch_q[$];
  strobe_t    strobe_q[$];

  cpu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .a_zero      (a_zero),
    .pc          (pc),
    .rom_en      (rom_en),
    .da          (da),
    .aa          (aa),
    .ba          (ba),
    .fs          (fs),
    .mb          (mb),
    .result_src  (result_src),
    .rw          (rw),
    .mw          (mw),
    .mem_req     (mem_req),
    .eoe         (eoe),
    .illegal     (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not match any expectation", name);
  endtask

  // Monitor: pops an expectation whenever the DUT fetches or strobes.
  initial begin
    strobe_t act, exp;
    logic [5:0] exp_pc;
    forever begin
      @(negedge clk);
      if (rom_en && instr_valid) begin
        if (fetch_q.size() == 0) fail("fetch_unexpected");
        else begin
          exp_pc = fetch_q.pop_front();
          chk("fetch_pc", pc, exp_pc);
        end
      end
      if (rw || (mw && mem_ready)) begin
        act = '{rw: rw, mw: mw, da: da, aa: aa, ba: ba, fs: fs, mb: mb, rs: result_src};
        if (strobe_q.size() == 0) fail("strobe_unexpected");
        else begin
          exp = strobe_q.pop_front();
          chk("strobe", act, exp);
        end
        if (rw && mw) fail("rw_mw_overlap");
      end
      if (mem_req) begin
        req_len++;
        if (mw) mw_len++;
      end else if (req_len != 0) begin
        last_req_len = req_len;
        last_mw_len  = mw_len;
        req_len      = 0;
        mw_len       = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] w, input logic az, input logic rdy,
                       input logic [5:0] exp_pc);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    instr       = w;
    a_zero      = az;
    mem_ready   = rdy;
    instr_valid = 1'b1;
    fetch_q.push_back(exp_pc);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rom_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("fetch_timeout");
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // With waits==0 mem_ready must already be high on entry to MEM.
  task automatic mem_phase(input int waits);
    bit ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail("mem_req_timeout");
      return;
    end
    if (waits > 0) begin
      repeat (waits) @(posedge clk);
      #1 mem_ready = 1'b1;
    end
    @(posedge clk);
    #1 mem_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    reset       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    a_zero      = 1'b0;
    #3;
    chk("reset_outs", {pc, rom_en, rw, mw, mem_req, eoe, illegal, fs, mb, result_src, da, aa, ba}, '0);
    repeat (2) @(negedge clk);
    chk("reset_held_outs", {pc, rom_en, rw, mw, mem_req, eoe, illegal}, '0);
    reset = 1'b1;

    // Fetch stalls with pc held at 0 until the ROM answers.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_pc", pc, 6'd0);
      chk("idle_rom_en", rom_en, 1'b1);
    end
    strobe_q.push_back('{rw: 1'b1, mw: 1'b0, da: 4'd1, aa: 4'd2, ba: 4'd3, fs: 3'b000, mb: 1'b0, rs: 2'b00});
    issue(16'h1123, 1'b0, 1'b0, 6'd0);

    // LD with three wait states: four request cycles, write-back on the last.
    strobe_q.push_back('{rw: 1'b1, mw: 1'b0, da: 4'd4, aa: 4'd5, ba: 4'd0, fs: 3'b000, mb: 1'b0, rs: 2'b01});
    issue(16'h8450, 1'b0, 1'b0, 6'd1);
    mem_phase(3);
    @(negedge clk);
    #1;
    chk("ld_req_len", last_req_len, 4);
    chk("ld_mw_len", last_mw_len, 0);

    // ST with mem_ready already high during FETCH/EXEC.
    strobe_q.push_back('{rw: 1'b0, mw: 1'b1, da: 4'd0, aa: 4'd6, ba: 4'd7, fs: 3'b000, mb: 1'b0, rs: 2'b00});
    issue(16'h9067, 1'b0, 1'b1, 6'd2);
    mem_phase(0);
    @(negedge clk);
    #1;
    chk("st_req_len", last_req_len, 1);
    chk("st_mw_len", last_mw_len, 1);

    issue(16'hC00A, 1'b0, 1'b0, 6'd3);
    issue(16'hB2F3, 1'b1, 1'b0, 6'd10);
    issue(16'hC00A, 1'b0, 1'b0, 6'd45);
    issue(16'hB2F3, 1'b0, 1'b0, 6'd10);
    issue(16'hC001, 1'b0, 1'b0, 6'd11);
    issue(16'hBF2E, 1'b1, 1'b0, 6'd1);
    issue(16'h0000, 1'b0, 1'b0, 6'd63);
    issue(16'hC03C, 1'b0, 1'b0, 6'd0);

    // Illegal opcode then HALT.
    chk("illegal_before", illegal, 1'b0);
    issue(16'hD000, 1'b0, 1'b0, 6'd60);
    issue(16'hF000, 1'b0, 1'b0, 6'd61);
    @(posedge clk);
    #1;
    instr       = 16'h1123;
    instr_valid = 1'b1;
    mem_ready   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_ctl", {eoe, rom_en, rw, mw, mem_req}, 5'b10000);
      chk("halt_pc", pc, 6'd61);
      chk("halt_illegal", illegal, 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    chk("halt_reset", {eoe, illegal, rom_en, pc}, '0);
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    #1 reset = 1'b1;

    // Reset during a stalled ST.
    issue(16'hC014, 1'b0, 1'b0, 6'd0);
    issue(16'h9067, 1'b0, 1'b0, 6'd20);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("st_mem_req_timeout");
    chk("st_mid_mw", {mem_req, mw, pc}, {1'b1, 1'b1, 6'd20});
    #2 reset = 1'b0;
    #1;
    chk("mid_mem_reset", {mem_req, mw, rw, eoe, illegal, pc}, '0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("fetch_q_empty", fetch_q.size(), 0);
    chk("strobe_q_empty", strobe_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
